mac_seq_ctrl: RTL and testbench

Sequencer that runs one dot-product job on the shared MAC datapath (registered accumulator, out <= out + x*w every clk, synchronous active-high clear).
- Accepts a start command with a vector length.
- Clears the MAC, streams LEN operand pairs into it through a valid/ready handshake, waits out the MAC latency, then captures the accumulator.
- Presents the result on a valid/ready output handshake.

---
 rtl/mac_seq_ctrl_if.sv | 43 ++++
 rtl/mac_seq_ctrl.sv | 121 ++++++++++++
 tb/tb_mac_seq_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/mac_seq_ctrl_if.sv
// Handshake and datapath bundle between the dot-product sequencer, its host and the shared MAC.
// MAC_CTRL_STALL_CNT_EN adds the stall_cnt observation field.
interface mac_seq_ctrl_if #(
   parameter int DW    = 16,
   parameter int ACC_W = 32,
   parameter int LEN_W = 8
);
   logic             start;
   logic [LEN_W-1:0] len;
   logic             busy;
   logic             in_valid;
   logic             in_ready;
   logic [DW-1:0]    in_x;
   logic [DW-1:0]    in_w;
   logic             mac_clr;
   logic [DW-1:0]    mac_x;
   logic [DW-1:0]    mac_w;
   logic [ACC_W-1:0] mac_out;
   logic [ACC_W-1:0] result;
   logic             result_valid;
   logic             result_ready;
`ifdef MAC_CTRL_STALL_CNT_EN
   logic [15:0]      stall_cnt;

   modport slave (
      input  start, len, in_valid, in_x, in_w, mac_out, result_ready,
      output busy, in_ready, mac_clr, mac_x, mac_w, result, result_valid, stall_cnt
   );
   modport master (
      output start, len, in_valid, in_x, in_w, mac_out, result_ready,
      input  busy, in_ready, mac_clr, mac_x, mac_w, result, result_valid, stall_cnt
   );
`else
   modport slave (
      input  start, len, in_valid, in_x, in_w, mac_out, result_ready,
      output busy, in_ready, mac_clr, mac_x, mac_w, result, result_valid
   );
   modport master (
      output start, len, in_valid, in_x, in_w, mac_out, result_ready,
      input  busy, in_ready, mac_clr, mac_x, mac_w, result, result_valid
   );
`endif
endinterface

// File: rtl/mac_seq_ctrl.sv
// Dot-product sequencer for a shared MAC: result_valid rises len+3 edges after start (no bubbles);
// in_ready only in RUN, result held in DONE until result_ready. MAC_CTRL_STALL_CNT_EN adds stall_cnt.
module mac_seq_ctrl #(
   parameter int DW    = 16,
   parameter int ACC_W = 32,
   parameter int LEN_W = 8
) (
   input  logic          clk,
   input  logic          rst,
   mac_seq_ctrl_if.slave bus
);
   typedef enum logic [2:0] {IDLE, CLR, RUN, DRAIN, CAPT, DONE} state_t;

   state_t           state, state_nxt;
   logic [LEN_W-1:0] cnt;
   logic [DW-1:0]    mac_x_q, mac_w_q;
   logic [ACC_W-1:0] result_q;
   logic             result_valid_q;
   logic             busy, in_rdy, clr;
   logic             start_ok, accept;

   assign start_ok = (state == IDLE) && bus.start && (bus.len != '0);
   assign accept   = (state == RUN) && bus.in_valid;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b1;
      in_rdy    = 1'b0;
      clr       = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start_ok) state_nxt = CLR;
         end
         CLR: begin
            clr       = 1'b1;
            state_nxt = RUN;
         end
         RUN: begin
            in_rdy = 1'b1;
            if (accept && cnt == LEN_W'(1)) state_nxt = DRAIN;
         end
         DRAIN:   state_nxt = CAPT;
         CAPT:    state_nxt = DONE;
         DONE:    if (bus.result_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Operand registers feed zeros whenever no pair is accepted so the MAC accumulates nothing.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt            <= '0;
         mac_x_q        <= '0;
         mac_w_q        <= '0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start_ok) begin
                  cnt     <= bus.len;
                  mac_x_q <= '0;
                  mac_w_q <= '0;
               end
            end
            CLR: begin
               mac_x_q <= '0;
               mac_w_q <= '0;
            end
            RUN: begin
               if (accept) begin
                  cnt     <= cnt - 1'b1;
                  mac_x_q <= bus.in_x;
                  mac_w_q <= bus.in_w;
               end else begin
                  mac_x_q <= '0;
                  mac_w_q <= '0;
               end
            end
            DRAIN: begin
               mac_x_q <= '0;
               mac_w_q <= '0;
            end
            CAPT: begin
               result_q       <= bus.mac_out;
               result_valid_q <= 1'b1;
            end
            DONE: begin
               if (bus.result_ready) result_valid_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy         = busy;
   assign bus.in_ready     = in_rdy;
   assign bus.mac_clr      = clr;
   assign bus.mac_x        = mac_x_q;
   assign bus.mac_w        = mac_w_q;
   assign bus.result       = result_q;
   assign bus.result_valid = result_valid_q;

`ifdef MAC_CTRL_STALL_CNT_EN
   logic [15:0] stall_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                                   stall_q <= '0;
      else if (start_ok)                                          stall_q <= '0;
      else if (state == RUN && !bus.in_valid && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
   end

   assign bus.stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl with a behavioural MAC and a result scoreboard.
module tb_mac_seq_ctrl;
   localparam int DW    = 16;
   localparam int ACC_W = 32;
   localparam int LEN_W = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   errors = 0;
   int   checks = 0;

   logic [DW-1:0]    px [0:255];
   logic [DW-1:0]    pw [0:255];
   logic [ACC_W-1:0] sb_q [$];
   logic [ACC_W-1:0] last_exp;
   logic [ACC_W-1:0] mac_acc = '0;

   mac_seq_ctrl_if #(.DW(DW), .ACC_W(ACC_W), .LEN_W(LEN_W)) bus ();

   mac_seq_ctrl #(.DW(DW), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Shared MAC datapath: registered accumulator with synchronous clear, not touched by rst.
   always @(posedge clk) begin
      if (bus.mac_clr) mac_acc <= '0;
      else             mac_acc <= mac_acc + ACC_W'(bus.mac_x) * ACC_W'(bus.mac_w);
   end
   assign bus.mac_out = mac_acc;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"},     64'(bus.busy), 64'd0);
      chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd0);
      chk({tag, "_mac_clr"},  64'(bus.mac_clr), 64'd0);
      chk({tag, "_mac_x"},    64'(bus.mac_x), 64'd0);
      chk({tag, "_mac_w"},    64'(bus.mac_w), 64'd0);
      chk({tag, "_result"},   64'(bus.result), 64'd0);
      chk({tag, "_rvalid"},   64'(bus.result_valid), 64'd0);
   endtask

   // Drives one job from px/pw, inserting bub_n RUN bubbles after bub_at accepted pairs.
   task automatic run_job(input string tag, input int L, input int bub_at, input int bub_n,
                          input int exp_lat, input bit keep_start);
      logic [ACC_W-1:0] acc;
      logic [ACC_W-1:0] exp;
      int idx, bubs, n, clr_cycles;
      bit seen;
      acc = '0;
      for (int i = 0; i < L; i++) acc = acc + ACC_W'(px[i]) * ACC_W'(pw[i]);
      sb_q.push_back(acc);
      @(negedge clk);
      chk({tag, "_idle_before"}, 64'(bus.busy), 64'd0);
      bus.start = 1'b1;
      bus.len   = LEN_W'(L);
      idx = 0; bubs = 0; n = 0; clr_cycles = 0; seen = 1'b0;
      while (n < 2000 && !seen) begin
         @(negedge clk);
         n++;
         if (!keep_start) bus.start = 1'b0;
         if (bus.mac_clr) clr_cycles++;
         if (bus.result_valid) begin
            seen = 1'b1;
         end else if (bus.in_ready && idx == bub_at && bubs < bub_n) begin
            bus.in_valid = 1'b0;
            bubs++;
         end else if (idx < L) begin
            bus.in_valid = 1'b1;
            bus.in_x     = px[idx];
            bus.in_w     = pw[idx];
            if (bus.in_ready) idx++;
         end else begin
            bus.in_valid = 1'b0;
         end
      end
      bus.in_valid = 1'b0;
      chk({tag, "_seen"}, 64'(seen), 64'd1);
      chk({tag, "_latency"}, 64'(n - 1), 64'(exp_lat));
      chk({tag, "_mac_clr_cycles"}, 64'(clr_cycles), 64'd1);
      exp = sb_q.pop_front();
      last_exp = exp;
      chk({tag, "_result"}, 64'(bus.result), 64'(exp));
   endtask

   // Holds off the consumer for hold cycles while pulsing start, then accepts the result.
   task automatic finish_job(input string tag, input int hold);
      bus.result_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         bus.start = (i % 2 == 0);
         bus.len   = LEN_W'(3);
         chk({tag, "_hold_rvalid"}, 64'(bus.result_valid), 64'd1);
         chk({tag, "_hold_result"}, 64'(bus.result), 64'(last_exp));
      end
      @(negedge clk);
      bus.start        = 1'b0;
      bus.result_ready = 1'b1;
      chk({tag, "_rvalid_at_take"}, 64'(bus.result_valid), 64'd1);
      @(negedge clk);
      bus.result_ready = 1'b0;
      chk({tag, "_busy_after"}, 64'(bus.busy), 64'd0);
      chk({tag, "_rvalid_after"}, 64'(bus.result_valid), 64'd0);
      chk({tag, "_result_holds"}, 64'(bus.result), 64'(last_exp));
      @(negedge clk);
      chk({tag, "_still_idle"}, 64'(bus.busy), 64'd0);
   endtask

   initial begin
      int acc_n, n;
      bus.start = 1'b0; bus.len = '0; bus.in_valid = 1'b0;
      bus.in_x = '0; bus.in_w = '0; bus.result_ready = 1'b0;

      repeat (2) @(negedge clk);
      chk_all_zero("reset");
      rst = 1'b1;

      px[0] = 16'd5; pw[0] = 16'd2; px[1] = 16'd3; pw[1] = 16'd4;
      px[2] = 16'd7; pw[2] = 16'd9; px[3] = 16'd8; pw[3] = 16'd6;
      run_job("basic", 4, 99, 0, 7, 1'b0);
      chk("basic_expected_133", 64'(bus.result), 64'd133);
`ifdef MAC_CTRL_STALL_CNT_EN
      chk("basic_stall_cnt", 64'(bus.stall_cnt), 64'd0);
`endif
      finish_job("bp", 5);

      run_job("bubble", 4, 2, 2, 9, 1'b0);
`ifdef MAC_CTRL_STALL_CNT_EN
      chk("bubble_stall_cnt", 64'(bus.stall_cnt), 64'd2);
`endif
      finish_job("bubble_fin", 1);
`ifdef MAC_CTRL_STALL_CNT_EN
      chk("stall_cnt_holds", 64'(bus.stall_cnt), 64'd2);
`endif

      @(negedge clk);
      bus.start = 1'b1; bus.len = '0;
      @(negedge clk);
      bus.start = 1'b0;
      chk("len0_busy", 64'(bus.busy), 64'd0);
      @(negedge clk);
      chk("len0_busy_late", 64'(bus.busy), 64'd0);
      chk("len0_in_ready", 64'(bus.in_ready), 64'd0);

      for (int i = 0; i < 256; i++) begin px[i] = 16'd1; pw[i] = 16'd1; end
      run_job("len255", 255, 999, 0, 258, 1'b0);
      finish_job("len255_fin", 0);

      // Abandon a len=4 job after two accepted pairs.
      px[0] = 16'd5; pw[0] = 16'd2; px[1] = 16'd3; pw[1] = 16'd4;
      px[2] = 16'd7; pw[2] = 16'd9; px[3] = 16'd8; pw[3] = 16'd6;
      @(negedge clk);
      bus.start = 1'b1; bus.len = LEN_W'(4);
      acc_n = 0; n = 0;
      while (acc_n < 2 && n < 20) begin
         @(negedge clk);
         n++;
         bus.start    = 1'b0;
         bus.in_valid = 1'b1;
         bus.in_x     = px[acc_n];
         bus.in_w     = pw[acc_n];
         if (bus.in_ready) acc_n++;
      end
      chk("midjob_pairs_taken", 64'(acc_n), 64'd2);
      @(negedge clk);
      chk("midjob_busy_before_rst", 64'(bus.busy), 64'd1);
      bus.in_valid = 1'b0;
      rst = 1'b0;
      #1;
      chk_all_zero("midjob_rst");
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midjob_idle", 64'(bus.busy), 64'd0);
      chk("midjob_no_result", 64'(bus.result_valid), 64'd0);
      px[0] = 16'd3; pw[0] = 16'd3;
      run_job("after_rst", 1, 99, 0, 4, 1'b0);
      chk("after_rst_expected_9", 64'(bus.result), 64'd9);
      finish_job("after_rst_fin", 0);

      // Back-to-back: start held high, consumer always ready.
      bus.result_ready = 1'b1;
      px[0] = 16'd4; pw[0] = 16'd5; px[1] = 16'd6; pw[1] = 16'd7; px[2] = 16'd1; pw[2] = 16'd9;
      run_job("b2b_first", 3, 99, 0, 6, 1'b1);
      px[0] = 16'd2; pw[0] = 16'd2; px[1] = 16'd2; pw[1] = 16'd2;
      run_job("b2b_second", 2, 99, 0, 5, 1'b0);
      chk("b2b_expected_8", 64'(bus.result), 64'd8);
      @(negedge clk);
      bus.result_ready = 1'b0;
      chk("b2b_idle", 64'(bus.busy), 64'd0);
      chk("sb_empty", 64'(sb_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
